// File: rtl/stream_pipe_slice.sv
// Multi-stage valid/ready register pipeline with an optional input skid register,
// synchronous flush and an occupancy count.
module stream_pipe_slice #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned SKID       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [DATA_WIDTH-1:0]         w_data,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [DATA_WIDTH-1:0]         r_data,
  output logic [$clog2(DEPTH+2)-1:0]    count
);

  localparam int unsigned CW  = $clog2(DEPTH + 2);
  localparam int unsigned CAP = DEPTH + ((SKID != 0) ? 1 : 0);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $fatal(1, "stream_pipe_slice: DEPTH must be at least 1");
    end
  endgenerate

  logic [DEPTH-1:0]      s_valid;
  logic [DATA_WIDTH-1:0] s_data [DEPTH];
  logic                  k_valid;
  logic [DATA_WIDTH-1:0] k_data;
  logic                  w_ready_q;
  logic [DEPTH-1:0]      adv;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  k_load;
  logic                  k_drain;

  // Advance chain: a stage may load when it is empty or its successor advances.
  always_comb begin
    logic a;
    adv = '0;
    a = !s_valid[DEPTH-1] || r_ready;
    adv[DEPTH-1] = a;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      a = !s_valid[i] || a;
      adv[i] = a;
    end
  end

  assign w_ready = (SKID != 0) ? w_ready_q : (!rst && adv[0]);
  assign r_valid = s_valid[DEPTH-1];
  assign r_data  = s_data[DEPTH-1];

  // Stage 0 source: the skid word has priority over the live input.
  always_comb begin
    in_xfer  = w_valid && w_ready;
    out_xfer = s_valid[DEPTH-1] && r_ready;
    if ((SKID != 0) && k_valid) begin
      src_valid = 1'b1;
      src_data  = k_data;
    end else begin
      src_valid = in_xfer;
      src_data  = w_data;
    end
    k_load  = (SKID != 0) && in_xfer && !adv[0];
    k_drain = k_valid && adv[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid   <= '0;
      k_valid   <= 1'b0;
      w_ready_q <= 1'b0;
      count     <= '0;
    end else if (flush) begin
      s_valid   <= '0;
      k_valid   <= 1'b0;
      w_ready_q <= 1'b1;
      count     <= '0;
    end else begin
      if (adv[0]) s_valid[0] <= src_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i]) s_valid[i] <= s_valid[i-1];
      end
      if (k_load) k_valid <= 1'b1;
      else if (k_drain) k_valid <= 1'b0;
      w_ready_q <= !(k_load || (k_valid && !k_drain));
      count     <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  // Payload registers need no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv[0]) s_data[0] <= src_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (adv[i]) s_data[i] <= s_data[i-1];
    end
    if (k_load) k_data <= w_data;
  end

  a_count_cap: assert property (@(posedge clk) disable iff (rst) count <= CW'(CAP));
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (r_valid && !r_ready && !flush) |=> $stable(r_data));

endmodule

// File: tb/tb_stream_pipe_slice.sv
// Scoreboard bench for stream_pipe_slice: DEPTH=3/SKID=1 main instance and a
// DEPTH=1/SKID=0 instance for the combinational-ready variant.
module tb_stream_pipe_slice;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       flush_a, w_valid_a, w_ready_a, r_valid_a, r_ready_a;
  logic [7:0] w_data_a, r_data_a;
  logic [2:0] count_a;

  logic       flush_b, w_valid_b, w_ready_b, r_valid_b, r_ready_b;
  logic [7:0] w_data_b, r_data_b;
  logic [1:0] count_b;

  stream_pipe_slice #(.DATA_WIDTH(8), .DEPTH(3), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a),
    .w_valid(w_valid_a), .w_ready(w_ready_a), .w_data(w_data_a),
    .r_valid(r_valid_a), .r_ready(r_ready_a), .r_data(r_data_a),
    .count(count_a)
  );

  stream_pipe_slice #(.DATA_WIDTH(8), .DEPTH(1), .SKID(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b),
    .w_valid(w_valid_b), .w_ready(w_ready_b), .w_data(w_data_b),
    .r_valid(r_valid_b), .r_ready(r_ready_b), .r_data(r_data_b),
    .count(count_b)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_a [$];
  logic [7:0] sb_b [$];
  logic [7:0] exp_a, exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the main instance: pop on output transfer, push accepted input.
  always @(negedge clk) begin
    if (rst) begin
      sb_a.delete();
    end else begin
      if (r_valid_a && r_ready_a) begin
        if (sb_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_out act=%0h req=none", r_data_a);
        end else begin
          exp_a = sb_a.pop_front();
          chk("a_out_data", 32'(r_data_a), 32'(exp_a));
        end
      end
      if (flush_a) sb_a.delete();
      else if (w_valid_a && w_ready_a) sb_a.push_back(w_data_a);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      sb_b.delete();
    end else begin
      chk("b_count_cap", 32'(count_b <= 2'd1), 32'd1);
      if (r_valid_b && r_ready_b) begin
        if (sb_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_out act=%0h req=none", r_data_b);
        end else begin
          exp_b = sb_b.pop_front();
          chk("b_out_data", 32'(r_data_b), 32'(exp_b));
        end
      end
      if (w_valid_b && w_ready_b) sb_b.push_back(w_data_b);
    end
  end

  task automatic send_a(input logic [7:0] d);
    bit acc;
    int n;
    w_valid_a = 1'b1;
    w_data_a  = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = w_ready_a;
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL a_send_timeout act=not_accepted req=accepted data=%0h", d);
    end
    w_valid_a = 1'b0;
  endtask

  task automatic fill_a();
    r_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) send_a(8'(8'h10 + i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit acc;
    rst = 1'b1;
    flush_a = 1'b0; w_valid_a = 1'b0; w_data_a = '0; r_ready_a = 1'b0;
    flush_b = 1'b0; w_valid_b = 1'b0; w_data_b = '0; r_ready_b = 1'b0;

    // 1. Reset values, release, then reset mid-stream.
    tick(); tick();
    chk("rst_r_valid", 32'(r_valid_a), 0);
    chk("rst_count", 32'(count_a), 0);
    chk("rst_w_ready", 32'(w_ready_a), 0);
    chk("rst_w_ready_b", 32'(w_ready_b), 0);
    rst = 1'b0;
    tick();
    chk("rel_w_ready", 32'(w_ready_a), 1);
    chk("rel_w_ready_b", 32'(w_ready_b), 1);
    send_a(8'hA1);
    send_a(8'hA2);
    chk("mid_count", 32'(count_a), 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_r_valid", 32'(r_valid_a), 0);
    chk("mid_rst_count", 32'(count_a), 0);
    chk("mid_rst_w_ready", 32'(w_ready_a), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rel_w_ready", 32'(w_ready_a), 1);
    chk("mid_rel_count", 32'(count_a), 0);

    // 2. Back-to-back stream with r_ready=1: latency 3, count steady at 3.
    r_ready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_valid_a = 1'b1;
      w_data_a  = 8'(i + 1);
      #1;
      chk("str_w_ready", 32'(w_ready_a), 1);
      tick();
      chk("str_r_valid", 32'(r_valid_a), (i >= 2) ? 1 : 0);
      chk("str_count", 32'(count_a), (i < 2) ? i + 1 : 3);
      if (i == 2) chk("str_first_data", 32'(r_data_a), 32'h01);
    end
    w_valid_a = 1'b0;
    repeat (4) tick();
    chk("str_drained", 32'(count_a), 0);
    chk("str_sb_empty", sb_a.size(), 0);

    // 3. Backpressure: exactly four words fit, then consecutive drain.
    r_ready_a = 1'b0;
    d = 8'h10;
    for (int i = 0; i < 8; i++) begin
      w_valid_a = 1'b1;
      w_data_a  = d;
      @(negedge clk);
      acc = w_ready_a;
      tick();
      if (acc) d++;
    end
    w_valid_a = 1'b0;
    chk("bp_accepted_next", 32'(d), 32'h14);
    chk("bp_w_ready", 32'(w_ready_a), 0);
    chk("bp_count", 32'(count_a), 4);
    chk("bp_r_data", 32'(r_data_a), 32'h10);
    r_ready_a = 1'b1;
    tick();
    chk("bp_w_ready_rise", 32'(w_ready_a), 1);
    chk("bp_d1", 32'(r_data_a), 32'h11);
    tick();
    chk("bp_d2", 32'(r_data_a), 32'h12);
    tick();
    chk("bp_d3", 32'(r_data_a), 32'h13);
    chk("bp_d3_valid", 32'(r_valid_a), 1);
    tick();
    chk("bp_empty", 32'(r_valid_a), 0);

    // 4. Full pipe with simultaneous output and new input.
    fill_a();
    chk("full_count", 32'(count_a), 4);
    chk("full_w_ready", 32'(w_ready_a), 0);
    r_ready_a = 1'b1;
    w_valid_a = 1'b1;
    w_data_a  = 8'h20;
    tick();
    chk("full_w_ready_next", 32'(w_ready_a), 1);
    chk("full_count_next", 32'(count_a), 3);
    chk("full_r_data_next", 32'(r_data_a), 32'h11);
    tick();
    w_valid_a = 1'b0;
    chk("full_count_inout", 32'(count_a), 3);
    chk("full_w_ready_inout", 32'(w_ready_a), 1);
    repeat (4) tick();
    chk("full_drained", 32'(count_a), 0);
    chk("full_sb_empty", sb_a.size(), 0);

    // 5. Flush with concurrent delivery; held flush drops accepted words.
    fill_a();
    chk("fl_count_pre", 32'(count_a), 4);
    flush_a   = 1'b1;
    w_valid_a = 1'b1;
    w_data_a  = 8'h30;
    r_ready_a = 1'b1;
    tick();
    chk("fl_count", 32'(count_a), 0);
    chk("fl_r_valid", 32'(r_valid_a), 0);
    chk("fl_w_ready", 32'(w_ready_a), 1);
    tick();
    chk("fl_hold_count", 32'(count_a), 0);
    chk("fl_hold_r_valid", 32'(r_valid_a), 0);
    chk("fl_hold_w_ready", 32'(w_ready_a), 1);
    flush_a   = 1'b0;
    w_valid_a = 1'b0;
    repeat (5) tick();
    chk("fl_after_r_valid", 32'(r_valid_a), 0);
    chk("fl_after_count", 32'(count_a), 0);

    // 6. SKID=0, DEPTH=1: ready follows r_ready combinationally.
    r_ready_b = 1'b0;
    w_valid_b = 1'b1;
    w_data_b  = 8'h40;
    #1;
    chk("b_w_ready_empty", 32'(w_ready_b), 1);
    tick();
    w_data_b = 8'h41;
    chk("b_r_valid", 32'(r_valid_b), 1);
    chk("b_r_data", 32'(r_data_b), 32'h40);
    chk("b_count", 32'(count_b), 1);
    #1;
    chk("b_w_ready_stall", 32'(w_ready_b), 0);
    r_ready_b = 1'b1;
    #1;
    chk("b_w_ready_hi", 32'(w_ready_b), 1);
    r_ready_b = 1'b0;
    #1;
    chk("b_w_ready_lo", 32'(w_ready_b), 0);
    r_ready_b = 1'b1;
    tick();
    w_valid_b = 1'b0;
    r_ready_b = 1'b0;
    chk("b_r_data2", 32'(r_data_b), 32'h41);
    chk("b_count2", 32'(count_b), 1);
    #1;
    chk("b_w_ready_lo2", 32'(w_ready_b), 0);
    tick();
    chk("b_stall_data", 32'(r_data_b), 32'h41);
    r_ready_b = 1'b1;
    tick();
    chk("b_empty", 32'(r_valid_b), 0);
    chk("b_count_end", 32'(count_b), 0);
    chk("b_sb_empty", sb_b.size(), 0);
    chk("a_sb_empty", sb_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
